// File: rtl/d_stage.sv
// Decode front end: F/D register with stall hold, rs/rt forwarding, and branch/jump resolution.
// One cycle from F to D; stall holds the register and forces D_Move to PC+4.
module d_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_Instr,
  input  logic [31:0] F_PC,
  input  logic        stall,
  input  logic [31:0] GRF_rd1,
  input  logic [31:0] GRF_rd2,
  input  logic [4:0]  E_wa,
  input  logic [31:0] E_wd,
  input  logic [4:0]  M_wa,
  input  logic [31:0] M_wd,
  output logic        D_Enable,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic [31:0] D_GRF_rs,
  output logic [31:0] D_GRF_rt,
  output logic [31:0] D_offset,
  output logic [25:0] D_Instr_index,
  output logic [2:0]  D_Move
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [2:0] MOVE_PC4    = 3'd0;
  localparam logic [2:0] MOVE_BRANCH = 3'd1;
  localparam logic [2:0] MOVE_JUMP   = 3'd2;
  localparam logic [2:0] MOVE_JREG   = 3'd3;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (!stall) begin
      instr_d = F_Instr;
      pc_d    = F_PC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'h0000_0000;
      pc_q    <= RESET_PC;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  // $0 always reads zero; E is younger than M so it wins.
  function automatic logic [31:0] fwd(input logic [4:0]  addr,
                                      input logic [31:0] grf,
                                      input logic [4:0]  e_wa,
                                      input logic [31:0] e_wd,
                                      input logic [4:0]  m_wa,
                                      input logic [31:0] m_wd);
    logic [31:0] val;
    val = grf;
    if (addr == 5'd0)
      val = 32'h0000_0000;
    else if (addr == e_wa)
      val = e_wd;
    else if (addr == m_wa)
      val = m_wd;
    return val;
  endfunction

  logic [5:0] op;
  logic [5:0] funct;
  logic       regs_equal;

  assign op    = instr_q[31:26];
  assign funct = instr_q[5:0];

  assign D_Enable      = ~stall;
  assign D_Instr       = instr_q;
  assign D_PC          = pc_q;
  assign D_PC8         = pc_q + 32'd8;
  assign D_rs          = instr_q[25:21];
  assign D_rt          = instr_q[20:16];
  assign D_offset      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign D_Instr_index = instr_q[25:0];

  assign D_GRF_rs = fwd(D_rs, GRF_rd1, E_wa, E_wd, M_wa, M_wd);
  assign D_GRF_rt = fwd(D_rt, GRF_rd2, E_wa, E_wd, M_wa, M_wd);
  assign regs_equal = (D_GRF_rs == D_GRF_rt);

  always_comb begin
    D_Move = MOVE_PC4;
    if (!stall) begin
      unique case (op)
        OP_BEQ:     if (regs_equal)  D_Move = MOVE_BRANCH;
        OP_BNE:     if (!regs_equal) D_Move = MOVE_BRANCH;
        OP_J,
        OP_JAL:     D_Move = MOVE_JUMP;
        OP_SPECIAL: if (funct == FN_JR || funct == FN_JALR) D_Move = MOVE_JREG;
        default:    D_Move = MOVE_PC4;
      endcase
    end
  end

endmodule

// File: tb/tb_d_stage.sv
// Directed bench for d_stage: reset, advance, stall, forwarding, $0 rule, jumps, reset during stall.
module tb_d_stage;
  logic        clk;
  logic        reset;
  logic [31:0] F_Instr, F_PC;
  logic        stall;
  logic [31:0] GRF_rd1, GRF_rd2;
  logic [4:0]  E_wa, M_wa;
  logic [31:0] E_wd, M_wd;
  logic        D_Enable;
  logic [31:0] D_Instr, D_PC, D_PC8, D_GRF_rs, D_GRF_rt, D_offset;
  logic [4:0]  D_rs, D_rt;
  logic [25:0] D_Instr_index;
  logic [2:0]  D_Move;

  int checks = 0;
  int errors = 0;

  d_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .F_Instr(F_Instr), .F_PC(F_PC), .stall(stall),
    .GRF_rd1(GRF_rd1), .GRF_rd2(GRF_rd2), .E_wa(E_wa), .E_wd(E_wd),
    .M_wa(M_wa), .M_wd(M_wd), .D_Enable(D_Enable), .D_Instr(D_Instr),
    .D_PC(D_PC), .D_PC8(D_PC8), .D_rs(D_rs), .D_rt(D_rt),
    .D_GRF_rs(D_GRF_rs), .D_GRF_rt(D_GRF_rt), .D_offset(D_offset),
    .D_Instr_index(D_Instr_index), .D_Move(D_Move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    stall   = 1'b0;
    F_Instr = 32'h1000_0003;
    F_PC    = 32'h0000_3000;
    GRF_rd1 = 32'd0;
    GRF_rd2 = 32'd0;
    E_wa = 5'd0; E_wd = 32'd0;
    M_wa = 5'd0; M_wd = 32'd0;

    // Reset state before any clock edge
    #2;
    check("rst_instr", D_Instr, 32'h0);
    check("rst_pc",    D_PC,    32'h0000_3000);
    check("rst_move",  {29'd0, D_Move}, 32'd0);
    check("rst_pc8",   D_PC8,   32'h0000_3008);
    check("rst_en",    {31'd0, D_Enable}, 32'd1);

    // Synchronous reset release, then beq $4,$5,+3 with equal operands
    @(negedge clk);
    reset   = 1'b0;
    F_PC    = 32'h0000_3004;
    F_Instr = 32'h1085_0003;
    GRF_rd1 = 32'd7;
    GRF_rd2 = 32'd7;
    tick();
    check("adv_pc",     D_PC,    32'h0000_3004);
    check("adv_instr",  D_Instr, 32'h1085_0003);
    check("adv_rs",     {27'd0, D_rs}, 32'd4);
    check("adv_rt",     {27'd0, D_rt}, 32'd5);
    check("beq_taken",  {29'd0, D_Move}, 32'd1);
    check("adv_offset", D_offset, 32'h0000_000C);
    GRF_rd2 = 32'd8;
    #1;
    check("beq_not_taken", {29'd0, D_Move}, 32'd0);
    GRF_rd2 = 32'd7;

    // Stall holds beq in D for two edges
    stall   = 1'b1;
    F_Instr = 32'h0800_0000;
    F_PC    = 32'h0000_3008;
    #1;
    check("stall_en",   {31'd0, D_Enable}, 32'd0);
    check("stall_move", {29'd0, D_Move}, 32'd0);
    tick();
    tick();
    check("stall_instr", D_Instr, 32'h1085_0003);
    check("stall_pc",    D_PC,    32'h0000_3004);
    stall = 1'b0;
    #1;
    check("unstall_en",   {31'd0, D_Enable}, 32'd1);
    check("unstall_move", {29'd0, D_Move}, 32'd1);
    tick();
    check("unstall_instr", D_Instr, 32'h0800_0000);
    check("unstall_pc",    D_PC,    32'h0000_3008);
    check("j_move",        {29'd0, D_Move}, 32'd2);

    // jr $31 with forwarding priority E > M > GRF
    F_Instr = 32'h03E0_0008;
    F_PC    = 32'h0000_300C;
    tick();
    E_wa = 5'd31; E_wd = 32'h0000_3100;
    M_wa = 5'd31; M_wd = 32'h0000_3200;
    GRF_rd1 = 32'h0000_3300;
    #1;
    check("fwd_e",   D_GRF_rs, 32'h0000_3100);
    check("jr_move", {29'd0, D_Move}, 32'd3);
    E_wa = 5'd0;
    #1;
    check("fwd_m", D_GRF_rs, 32'h0000_3200);
    M_wa = 5'd0;
    #1;
    check("fwd_grf", D_GRF_rs, 32'h0000_3300);

    // jalr $31,$31
    F_Instr = 32'h03E0_F809;
    F_PC    = 32'h0000_3010;
    tick();
    check("jalr_move", {29'd0, D_Move}, 32'd3);

    // beq $0,$0,-1: $0 reads zero even with data on the read ports
    F_Instr = 32'h1000_FFFF;
    F_PC    = 32'h0000_3014;
    E_wa = 5'd0; E_wd = 32'd5;
    GRF_rd1 = 32'd9;
    GRF_rd2 = 32'd3;
    tick();
    check("zero_rs",    D_GRF_rs, 32'h0);
    check("zero_rt",    D_GRF_rt, 32'h0);
    check("zero_taken", {29'd0, D_Move}, 32'd1);
    check("neg_offset", D_offset, 32'hFFFF_FFFC);

    // bne $4,$5 with rt forwarded from E
    F_Instr = 32'h1485_0001;
    F_PC    = 32'h0000_3018;
    GRF_rd1 = 32'd7;
    GRF_rd2 = 32'd1;
    E_wa = 5'd5; E_wd = 32'd7;
    tick();
    check("bne_fwd_rt",    D_GRF_rt, 32'd7);
    check("bne_not_taken", {29'd0, D_Move}, 32'd0);
    E_wd = 32'd8;
    #1;
    check("bne_taken", {29'd0, D_Move}, 32'd1);
    E_wa = 5'd0;

    // jal with PC at the top of the address space: PC8 wraps
    F_Instr = 32'h0C00_0C03;
    F_PC    = 32'hFFFF_FFFC;
    tick();
    check("jal_move",  {29'd0, D_Move}, 32'd2);
    check("jal_index", {6'd0, D_Instr_index}, 32'h0000_0C03);
    check("jal_pc8",   D_PC8, 32'h0000_0004);

    // Reset asserted mid-stall takes effect without a clock edge
    stall   = 1'b1;
    F_Instr = 32'h1000_0003;
    F_PC    = 32'h0000_4000;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_instr", D_Instr, 32'h0);
    check("midrst_pc",    D_PC,    32'h0000_3000);
    check("midrst_move",  {29'd0, D_Move}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    tick();
    check("post_rst_instr", D_Instr, 32'h1000_0003);
    check("post_rst_pc",    D_PC,    32'h0000_4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
